fifo_param: RTL and testbench
=============================

// Module: fifo_param
// PURPOSE
//  Parametrised synchronous FIFO for the FIFO datapath. Built on an internal
//  DEPTH x DATA_WIDTH register bank with one-hot write enables.
//  Adds several features absent from the fixed 8x32 bank:
//  - configurable width and depth
//  - head/tail pointers and an occupancy count
//  - full/empty flags and ack/error handshake pulses
//  - simultaneous read and write in one cycle
// PARAMETERS
//  DATA_WIDTH  32  bits per entry
//  DEPTH       8   number of entries; power of two, >= 2
//  AW          3   pointer width = log2(DEPTH); the parent must keep it consistent
// PORTS
//  clk         in   1             rising-edge clock; the only clock
//  reset       in   1             reset is synchronous and active-high
//  wr_en       in   1             write request
//  rd_en       in   1             read request
//  d_in        in   DATA_WIDTH    write data, sampled on clk when wr_en is high
//  d_out       out  DATA_WIDTH    read data, registered
//  full        out  1             count == DEPTH (combinational from count)
//  empty       out  1             count == 0 (combinational from count)
//  wr_ack      out  1             registered pulse: previous-cycle write accepted
//  wr_err      out  1             registered pulse: previous-cycle write rejected
//  rd_ack      out  1             registered pulse: previous-cycle read accepted
//  rd_err      out  1             registered pulse: previous-cycle read rejected
//  data_count  out  AW+1          current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//   - head, tail and count are cleared to 0; state goes to IDLE.
//   - d_out, wr_ack, wr_err, rd_ack and rd_err are cleared to 0.
//   - empty=1, full=0.
//   - Register bank contents are don't-care.
//   - Reset overrides any wr_en/rd_en in the same cycle. Reset mid-stream
//     discards all entries.
//  State register (encodes the last operation): IDLE, WRITE, READ, WR_RD,
//   WR_ERR, RD_ERR. The next state is decoded each cycle from
//   {wr_en, rd_en, full, empty}. Flags are decoded from the state register,
//   so each flag is high for exactly 1 cycle per request.
//  Decode table (values before the edge):
//   - wr only, !full  -> WRITE: mem[tail]<=d_in, tail++, count++, wr_ack=1
//   - wr only, full   -> WR_ERR: no change, wr_err=1
//   - rd only, !empty -> READ: d_out<=mem[head], head++, count--, rd_ack=1
//   - rd only, empty  -> RD_ERR: no change, d_out holds, rd_err=1
//   - wr&rd, neither full nor empty -> WR_RD: both accepted, count unchanged,
//     wr_ack=rd_ack=1
//   - wr&rd, full  -> WR_RD: read frees the slot, so both are accepted;
//     count stays DEPTH
//   - wr&rd, empty -> write accepted (count=1), read rejected; wr_ack=1 and
//     rd_err=1 in the same cycle. No bypass of d_in to d_out.
//   - neither -> IDLE: all four flags are 0.
//  Read latency: 1 clk. d_out is valid the cycle after the accepted rd_en,
//   together with rd_ack. d_out holds its value until the next accepted read.
//  Pointers wrap modulo DEPTH (AW-bit natural wrap). count is never
//   below 0 and never above DEPTH.
//  Register bank write enable: one-hot decode of tail, gated by write acceptance.
// TESTING
//  1. reset, idle -> empty=1, full=0, data_count=0, d_out=0, all flags 0.
//  2. Write 0x11..0x88 (8 writes, DEPTH=8) -> wr_ack on each cycle,
//     full=1 after the 8th, data_count=8; a 9th write -> wr_err=1,
//     data unchanged.
//  3. 8 reads after test 2 -> d_out=0x11..0x88 in order, 1 cycle after each
//     rd_en; empty=1 at the end; a 9th read -> rd_err=1, d_out stays 0x88.
//  4. Wrap-around: 5 writes, 5 reads, then 6 writes and 6 reads -> data is in
//     order across the pointer wrap; data_count goes 0->6->0.
//  5. Simultaneous wr&rd: at count=3 -> count stays 3, wr_ack=rd_ack=1;
//     at full -> both acked, count stays 8; at empty -> wr_ack=1, rd_err=1,
//     count=1.
//  6. Assert reset with count=4 while wr_en=1 -> next cycle count=0, empty=1,
//     all flags 0, write discarded.

Source files
------------

// File: rtl/fifo_param_if.sv
// Handshake and data bundle between a FIFO user (master) and fifo_param (slave).
// The parent keeps AW consistent with the FIFO depth.
interface fifo_param_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned AW         = 3
);
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] d_in;
   logic [DATA_WIDTH-1:0] d_out;
   logic                  full;
   logic                  empty;
   logic                  wr_ack;
   logic                  wr_err;
   logic                  rd_ack;
   logic                  rd_err;
   logic [AW:0]           data_count;

   modport master (
      output wr_en, rd_en, d_in,
      input  d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count
   );

   modport slave (
      input  wr_en, rd_en, d_in,
      output d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count
   );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: register bank with one-hot write enables, head/tail
// pointers, occupancy count, and ack/error pulses decoded from a last-operation state.
module fifo_param #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned AW         = 3
) (
   input logic          clk,
   input logic          reset,
   fifo_param_if.slave  fifo_io
);

   // Last-operation encoding; StWrRdErr covers wr&rd on empty (write taken, read refused).
   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StWrite   = 3'd1;
   localparam logic [2:0] StRead    = 3'd2;
   localparam logic [2:0] StWrRd    = 3'd3;
   localparam logic [2:0] StWrErr   = 3'd4;
   localparam logic [2:0] StRdErr   = 3'd5;
   localparam logic [2:0] StWrRdErr = 3'd6;

   localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);

   logic [2:0]            state_q, state_d;
   logic [AW-1:0]         head_q, head_d;
   logic [AW-1:0]         tail_q, tail_d;
   logic [AW:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   logic             full, empty;
   logic             wr_accept, rd_accept;
   logic [DEPTH-1:0] wr_sel;

   assign full  = (count_q == CountFull);
   assign empty = (count_q == '0);

   always_comb begin
      state_d   = StIdle;
      wr_accept = 1'b0;
      rd_accept = 1'b0;
      unique case ({fifo_io.wr_en, fifo_io.rd_en})
         2'b10: begin
            if (full) begin
               state_d = StWrErr;
            end else begin
               state_d   = StWrite;
               wr_accept = 1'b1;
            end
         end
         2'b01: begin
            if (empty) begin
               state_d = StRdErr;
            end else begin
               state_d   = StRead;
               rd_accept = 1'b1;
            end
         end
         2'b11: begin
            // On full the read frees the slot the write lands in, so both proceed.
            if (empty) begin
               state_d   = StWrRdErr;
               wr_accept = 1'b1;
            end else begin
               state_d   = StWrRd;
               wr_accept = 1'b1;
               rd_accept = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      head_d  = rd_accept ? head_q + AW'(1) : head_q;
      tail_d  = wr_accept ? tail_q + AW'(1) : tail_q;
      d_out_d = rd_accept ? mem_q[head_q] : d_out_q;
      count_d = count_q;
      unique case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      wr_sel = wr_accept ? (DEPTH'(1) << tail_q) : '0;
      mem_d  = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_sel[i]) begin
            mem_d[i] = fifo_io.d_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         d_out_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         d_out_q <= d_out_d;
      end
   end

   // Bank contents are don't-care after reset, so no reset on storage.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign fifo_io.d_out      = d_out_q;
   assign fifo_io.full       = full;
   assign fifo_io.empty      = empty;
   assign fifo_io.data_count = count_q;
   assign fifo_io.wr_ack     = (state_q == StWrite) || (state_q == StWrRd)
                               || (state_q == StWrRdErr);
   assign fifo_io.wr_err     = (state_q == StWrErr);
   assign fifo_io.rd_ack     = (state_q == StRead) || (state_q == StWrRd);
   assign fifo_io.rd_err     = (state_q == StRdErr) || (state_q == StWrRdErr);

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a vector table for fill/drain, plus hand sequences
// for wrap-around, simultaneous access and mid-stream reset.
module tb_fifo_param;

   typedef struct {
      logic        rst;
      logic        wr;
      logic        rd;
      logic [31:0] din;
      logic [31:0] dout;
      logic        full;
      logic        empty;
      logic        wr_ack;
      logic        wr_err;
      logic        rd_ack;
      logic        rd_err;
      logic [3:0]  cnt;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs[$];

   fifo_param_if #(.DATA_WIDTH(32), .AW(3)) bus ();

   fifo_param #(.DATA_WIDTH(32), .DEPTH(8), .AW(3)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .fifo_io (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic rst, logic wr, logic rd, logic [31:0] din,
                               logic [31:0] dout, logic full, logic empty, logic wa,
                               logic we, logic ra, logic re, logic [3:0] cnt);
      vec_t v;
      v.rst = rst; v.wr = wr; v.rd = rd; v.din = din; v.dout = dout; v.full = full;
      v.empty = empty; v.wr_ack = wa; v.wr_err = we; v.rd_ack = ra; v.rd_err = re;
      v.cnt = cnt;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(logic rst, logic wr, logic rd, logic [31:0] din);
      reset     = rst;
      bus.wr_en = wr;
      bus.rd_en = rd;
      bus.d_in  = din;
      @(posedge clk);
      #1;
   endtask

   task automatic check_flags(string name, logic wa, logic we, logic ra, logic re,
                              logic [3:0] cnt);
      check({name, ".flags"}, {28'd0, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err},
            {28'd0, wa, we, ra, re});
      check({name, ".count"}, {28'd0, bus.data_count}, {28'd0, cnt});
      check({name, ".full_empty"}, {30'd0, bus.full, bus.empty},
            {30'd0, cnt == 4'd8, cnt == 4'd0});
   endtask

   initial begin
      reset     = 1'b1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.d_in  = '0;

      // Reset, idle, fill 0x11..0x88, overflow, drain, underflow.
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(0, 1, 0, 32'h11 * (i + 1), 0, i == 7, 0, 1, 0, 0, 0,
                           4'(i + 1)));
      end
      vecs.push_back(mk(0, 1, 0, 32'h99, 0, 1, 0, 0, 1, 0, 0, 8));
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(0, 0, 1, 0, 32'h11 * (i + 1), 0, i == 7, 0, 0, 1, 0,
                           4'(7 - i)));
      end
      vecs.push_back(mk(0, 0, 1, 0, 32'h88, 0, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h88, 0, 1, 0, 0, 0, 0, 0));

      @(negedge clk);
      foreach (vecs[k]) begin
         vec_t v;
         logic [41:0] act, exp;
         v = vecs[k];
         step(v.rst, v.wr, v.rd, v.din);
         act = {bus.d_out, bus.full, bus.empty, bus.wr_ack, bus.wr_err, bus.rd_ack,
                bus.rd_err, bus.data_count};
         exp = {v.dout, v.full, v.empty, v.wr_ack, v.wr_err, v.rd_ack, v.rd_err, v.cnt};
         n_cmp++;
         if (act !== exp) begin
            n_bad++;
            $display("FAIL vec[%0d]: got dout=%h f/e=%b%b wa/we/ra/re=%b%b%b%b cnt=%0d, expected dout=%h f/e=%b%b wa/we/ra/re=%b%b%b%b cnt=%0d",
                     k, bus.d_out, bus.full, bus.empty, bus.wr_ack, bus.wr_err,
                     bus.rd_ack, bus.rd_err, bus.data_count, v.dout, v.full, v.empty,
                     v.wr_ack, v.wr_err, v.rd_ack, v.rd_err, v.cnt);
         end
      end

      // Wrap-around: 5 in/5 out, then 6 in/6 out crossing the pointer wrap.
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 32'hA0 + i);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 0);
         check("wrap1.dout", bus.d_out, 32'hA0 + i);
      end
      for (int i = 0; i < 6; i++) step(0, 1, 0, 32'hB0 + i);
      check_flags("wrap.filled", 1, 0, 0, 0, 6);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1, 0);
         check("wrap2.dout", bus.d_out, 32'hB0 + i);
      end
      check_flags("wrap.drained", 0, 0, 1, 0, 0);

      // Simultaneous read/write at count=3, then at full.
      step(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 32'hC0 + i);
      step(0, 1, 1, 32'hC3);
      check_flags("wr_rd.mid", 1, 0, 1, 0, 3);
      check("wr_rd.mid.dout", bus.d_out, 32'hC0);
      for (int i = 4; i < 9; i++) step(0, 1, 0, 32'hC0 + i);
      check_flags("fill.full", 1, 0, 0, 0, 8);
      step(0, 1, 1, 32'hC9);
      check_flags("wr_rd.full", 1, 0, 1, 0, 8);
      check("wr_rd.full.dout", bus.d_out, 32'hC1);

      // Simultaneous read/write on empty: write taken, read refused, no bypass.
      step(1, 0, 0, 0);
      step(0, 1, 1, 32'hD5);
      check_flags("wr_rd.empty", 1, 0, 0, 1, 1);
      check("wr_rd.empty.dout", bus.d_out, 32'h0);
      step(0, 0, 1, 0);
      check("wr_rd.empty.read", bus.d_out, 32'hD5);

      // Reset with 4 entries and a concurrent write discards everything.
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 32'hE0 + i);
      step(0, 0, 1, 0);
      check("pre_rst.dout", bus.d_out, 32'hE0);
      step(0, 1, 0, 32'hE4);
      step(1, 1, 0, 32'hEF);
      check_flags("mid_rst", 0, 0, 0, 0, 0);
      check("mid_rst.dout", bus.d_out, 32'h0);
      step(0, 0, 1, 0);
      check_flags("post_rst.read", 0, 0, 0, 1, 0);
      check("post_rst.dout", bus.d_out, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
